// File: rtl/uint_accum_stage.sv
// Registered accumulation stage: sums COUNT accepted samples into one result with carry tracking.
// Optional feature: define UINT_ACCUM_SATURATE_EN to clamp the accumulator on carry instead of wrapping.
module uint_accum_stage #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned COUNT = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [WIDTH-1:0] I,
   input  logic             I_valid,
   output logic             I_ready,
   output logic [WIDTH-1:0] O,
   output logic             O_valid,
   input  logic             O_ready,
   output logic             O_overflow
);

   localparam int unsigned     CW       = $clog2(COUNT + 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(COUNT);

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH-1:0] o_q, o_d;
   logic             o_valid_q, o_valid_d;
   logic             o_ovf_q, o_ovf_d;

   logic             accept;
   logic             consume;
   logic             first;
   logic [WIDTH:0]   sum;
   logic             carry;
   logic [WIDTH-1:0] acc_next;
   logic             ovf_next;
   logic [CW-1:0]    cnt_next;
   logic             complete;

   assign I_ready    = !o_valid_q || O_ready;
   assign accept     = I_valid && I_ready;
   assign consume    = o_valid_q && O_ready;

   assign O          = o_q;
   assign O_valid    = o_valid_q;
   assign O_overflow = o_ovf_q;

   always_comb begin
      sum      = {1'b0, acc_q} + {1'b0, I};
      carry    = sum[WIDTH];
      first    = (cnt_q == '0);
      acc_next = I;
      ovf_next = 1'b0;
      if (!first) begin
`ifdef UINT_ACCUM_SATURATE_EN
         // A clamped all-ones acc carries on any nonzero add, so it stays clamped.
         acc_next = carry ? '1 : sum[WIDTH-1:0];
`else
         acc_next = sum[WIDTH-1:0];
`endif
         ovf_next = ovf_q | carry;
      end
      cnt_next = cnt_q + CW'(1);
      complete = (cnt_next == CNT_LAST);
   end

   always_comb begin
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      o_d       = o_q;
      o_valid_d = o_valid_q;
      o_ovf_d   = o_ovf_q;

      if (consume) begin
         o_valid_d = 1'b0;
      end

      if (accept) begin
         acc_d = acc_next;
         ovf_d = ovf_next;
         if (complete) begin
            // Completing accept wins over a same-cycle consume: new result replaces the old.
            o_d       = acc_next;
            o_ovf_d   = ovf_next;
            o_valid_d = 1'b1;
            cnt_d     = '0;
         end else begin
            cnt_d = cnt_next;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         acc_q     <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         o_q       <= '0;
         o_valid_q <= 1'b0;
         o_ovf_q   <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         o_q       <= o_d;
         o_valid_q <= o_valid_d;
         o_ovf_q   <= o_ovf_d;
      end
   end

endmodule

// File: tb/tb_uint_accum_stage.sv
// Directed bench for uint_accum_stage: COUNT=4 main instance plus a COUNT=1 instance.
module tb_uint_accum_stage;

   logic       CLK = 1'b0;
   logic       RESET;
   logic [7:0] I;
   logic       I_valid;
   logic       I_ready;
   logic [7:0] O;
   logic       O_valid;
   logic       O_ready;
   logic       O_overflow;

   logic [7:0] I1;
   logic       I1_valid;
   logic       I1_ready;
   logic [7:0] O1;
   logic       O1_valid;
   logic       O1_ready;
   logic       O1_overflow;

   int passed = 0;
   int total  = 0;

   always #5 CLK = ~CLK;

   uint_accum_stage #(.WIDTH(8), .COUNT(4)) dut (
      .CLK(CLK), .RESET(RESET),
      .I(I), .I_valid(I_valid), .I_ready(I_ready),
      .O(O), .O_valid(O_valid), .O_ready(O_ready), .O_overflow(O_overflow)
   );

   uint_accum_stage #(.WIDTH(8), .COUNT(1)) dut1 (
      .CLK(CLK), .RESET(RESET),
      .I(I1), .I_valid(I1_valid), .I_ready(I1_ready),
      .O(O1), .O_valid(O1_valid), .O_ready(O1_ready), .O_overflow(O1_overflow)
   );

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RESET = 1'b1; I = 8'd0; I_valid = 1'b0; O_ready = 1'b1;
      I1 = 8'd0; I1_valid = 1'b0; O1_ready = 1'b1;
      step();
      step();
      RESET = 1'b0;
      total++; if (O_valid !== 1'b0) $display("FAIL reset_O_valid got %b exp 0", O_valid); else passed++;
      total++; if (O !== 8'd0) $display("FAIL reset_O got %0d exp 0", O); else passed++;
      total++; if (O_overflow !== 1'b0) $display("FAIL reset_O_overflow got %b exp 0", O_overflow); else passed++;
      total++; if (I_ready !== 1'b1) $display("FAIL reset_I_ready got %b exp 1", I_ready); else passed++;
      total++; if (O1_valid !== 1'b0) $display("FAIL reset_O1_valid got %b exp 0", O1_valid); else passed++;
   endtask

   task automatic test_basic();
      logic [7:0] s [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
      O_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         I = s[k]; I_valid = 1'b1;
         step();
         if (k < 3) begin
            total++; if (O_valid !== 1'b0) $display("FAIL basic_early_valid k=%0d got %b exp 0", k, O_valid); else passed++;
         end
      end
      I_valid = 1'b0;
      total++; if (O_valid !== 1'b1) $display("FAIL basic_O_valid got %b exp 1", O_valid); else passed++;
      total++; if (O !== 8'd10) $display("FAIL basic_O got %0d exp 10", O); else passed++;
      total++; if (O_overflow !== 1'b0) $display("FAIL basic_O_overflow got %b exp 0", O_overflow); else passed++;
      step();
      total++; if (O_valid !== 1'b0) $display("FAIL basic_one_cycle got %b exp 0", O_valid); else passed++;
      total++; if (O !== 8'd10) $display("FAIL basic_O_kept got %0d exp 10", O); else passed++;
   endtask

   task automatic test_overflow();
      logic [7:0] s [4] = '{8'd200, 8'd100, 8'd0, 8'd0};
      logic [7:0] exp_o;
`ifdef UINT_ACCUM_SATURATE_EN
      exp_o = 8'd255;
`else
      exp_o = 8'd44;
`endif
      O_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         I = s[k]; I_valid = 1'b1;
         step();
      end
      I_valid = 1'b0;
      total++; if (O_valid !== 1'b1) $display("FAIL ovf_O_valid got %b exp 1", O_valid); else passed++;
      total++; if (O !== exp_o) $display("FAIL ovf_O got %0d exp %0d", O, exp_o); else passed++;
      total++; if (O_overflow !== 1'b1) $display("FAIL ovf_flag got %b exp 1", O_overflow); else passed++;
      step();
   endtask

   task automatic test_backpressure();
      O_ready = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         I = 8'(k); I_valid = 1'b1;
         step();
      end
      I = 8'd99; I_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         total++; if (I_ready !== 1'b0) $display("FAIL bp_I_ready c=%0d got %b exp 0", k, I_ready); else passed++;
         total++; if (O !== 8'd10 || O_valid !== 1'b1) $display("FAIL bp_hold c=%0d got O=%0d v=%b exp O=10 v=1", k, O, O_valid); else passed++;
         step();
      end
      O_ready = 1'b1; I = 8'd7;
      #1;
      total++; if (I_ready !== 1'b1) $display("FAIL bp_release_ready got %b exp 1", I_ready); else passed++;
      step();
      total++; if (O_valid !== 1'b0) $display("FAIL bp_consumed got %b exp 0", O_valid); else passed++;
      for (int k = 0; k < 3; k++) begin
         I = 8'd1;
         step();
      end
      I_valid = 1'b0;
      total++; if (O_valid !== 1'b1 || O !== 8'd10) $display("FAIL bp_next_result got O=%0d v=%b exp O=10 v=1", O, O_valid); else passed++;
      total++; if (O_overflow !== 1'b0) $display("FAIL bp_next_ovf got %b exp 0", O_overflow); else passed++;
      step();
   endtask

   task automatic test_bubbles();
      logic [7:0] s [7] = '{8'd5, 8'd0, 8'd0, 8'd6, 8'd0, 8'd7, 8'd8};
      logic       v [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      O_ready = 1'b1;
      for (int k = 0; k < 7; k++) begin
         I = (v[k]) ? s[k] : 8'd77; I_valid = v[k];
         step();
         if (k < 6) begin
            total++; if (O_valid !== 1'b0) $display("FAIL bub_early k=%0d got %b exp 0", k, O_valid); else passed++;
         end
      end
      I_valid = 1'b0;
      total++; if (O_valid !== 1'b1 || O !== 8'd26) $display("FAIL bub_O got O=%0d v=%b exp O=26 v=1", O, O_valid); else passed++;
      step();
   endtask

   task automatic test_back_to_back();
      O_ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         I = 8'(k); I_valid = 1'b1;
         step();
         if (k == 4) begin
            total++; if (O !== 8'd10 || O_valid !== 1'b1) $display("FAIL b2b_first got O=%0d v=%b exp O=10 v=1", O, O_valid); else passed++;
         end
         if (k == 5) begin
            total++; if (O_valid !== 1'b0) $display("FAIL b2b_gap got %b exp 0", O_valid); else passed++;
         end
      end
      I_valid = 1'b0;
      total++; if (O !== 8'd26 || O_valid !== 1'b1) $display("FAIL b2b_second got O=%0d v=%b exp O=26 v=1", O, O_valid); else passed++;
      step();
   endtask

   task automatic test_reset_mid();
      O_ready = 1'b1;
      I = 8'd9; I_valid = 1'b1;
      step();
      step();
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      total++; if (O !== 8'd0 || O_valid !== 1'b0) $display("FAIL rst_mid_clear got O=%0d v=%b exp O=0 v=0", O, O_valid); else passed++;
      I = 8'd1;
      for (int k = 0; k < 4; k++) begin
         step();
         if (k < 3) begin
            total++; if (O_valid !== 1'b0) $display("FAIL rst_mid_partial k=%0d got %b exp 0", k, O_valid); else passed++;
         end
      end
      I_valid = 1'b0;
      total++; if (O !== 8'd4 || O_valid !== 1'b1) $display("FAIL rst_mid_O got O=%0d v=%b exp O=4 v=1", O, O_valid); else passed++;
      total++; if (O_overflow !== 1'b0) $display("FAIL rst_mid_ovf got %b exp 0", O_overflow); else passed++;
      step();
   endtask

   task automatic test_count1();
      logic [7:0] s [3] = '{8'd3, 8'd4, 8'd5};
      O1_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         I1 = s[k]; I1_valid = 1'b1;
         step();
         total++; if (O1 !== s[k] || O1_valid !== 1'b1) $display("FAIL c1_O k=%0d got O=%0d v=%b exp O=%0d v=1", k, O1, O1_valid, s[k]); else passed++;
         total++; if (O1_overflow !== 1'b0) $display("FAIL c1_ovf k=%0d got %b exp 0", k, O1_overflow); else passed++;
      end
      I1_valid = 1'b0;
      step();
      total++; if (O1_valid !== 1'b0) $display("FAIL c1_drain got %b exp 0", O1_valid); else passed++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_backpressure();
      test_bubbles();
      test_back_to_back();
      test_reset_mid();
      test_count1();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
